// File: rtl/dlfloat_pkg.sv
// Shared widths, flag positions, rounding modes and special encodings for the
// DLFloat16 datapath stages.
package dlfloat_pkg;

  localparam int EXP_W  = 6;
  localparam int MAN_W  = 9;
  localparam int EXT_W  = 4;
  localparam int BIAS   = 31;
  localparam int FRAC_W = MAN_W + EXT_W;
  localparam int IN_W   = 1 + EXP_W + FRAC_W;
  localparam int OUT_W  = 1 + EXP_W + MAN_W;
  localparam int FLG_W  = 5;

  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_DZ  = 3;
  localparam int FLG_INV = 4;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rnd_mode_e;

  localparam logic [EXP_W-1:0] EXP_MAX     = '1;
  localparam logic [EXP_W-1:0] EXP_TOP_FIN = {{(EXP_W-1){1'b1}}, 1'b0};

  localparam logic [OUT_W-2:0] MAG_INF     = {EXP_MAX, {MAN_W{1'b0}}};
  localparam logic [OUT_W-2:0] MAG_MAX_FIN = {EXP_TOP_FIN, {MAN_W{1'b1}}};

  localparam logic [OUT_W-1:0] POS_INF     = {1'b0, MAG_INF};
  localparam logic [OUT_W-1:0] NEG_INF     = {1'b1, MAG_INF};
  localparam logic [OUT_W-1:0] POS_MAX_FIN = {1'b0, MAG_MAX_FIN};
  localparam logic [OUT_W-1:0] NEG_MAX_FIN = {1'b1, MAG_MAX_FIN};
  localparam logic [OUT_W-1:0] CANON_NAN   = {1'b0, {(OUT_W-1){1'b1}}};

  // Saturated result when rounding carries into the all-ones exponent.
  function automatic logic [OUT_W-1:0] ovf_result(input logic sign, input rnd_mode_e mode);
    logic to_inf;
    case (mode)
      RNE:     to_inf = 1'b1;
      RTZ:     to_inf = 1'b0;
      RUP:     to_inf = ~sign;
      default: to_inf = sign;
    endcase
    return {sign, to_inf ? MAG_INF : MAG_MAX_FIN};
  endfunction

endpackage

// File: rtl/dlfloat_rnd_decide.sv
// Rounding-direction decision from sign, lsb, guard and sticky; reused by the
// other DLFloat rounding stages.
module dlfloat_rnd_decide
  import dlfloat_pkg::*;
(
  input  logic      sign,
  input  logic      lsb,
  input  logic      g,
  input  logic      s,
  input  rnd_mode_e mode,
  output logic      incr,
  output logic      inexact
);

  assign inexact = g | s;

  always_comb begin
    incr = 1'b0;
    case (mode)
      RNE:     incr = g & (s | lsb);
      RTZ:     incr = 1'b0;
      RUP:     incr = ~sign & (g | s);
      RDN:     incr = sign & (g | s);
      default: incr = 1'b0;
    endcase
  end

endmodule

// File: rtl/dlfloat_round.sv
// Two-stage valid/ready rounding stage: divider extended result -> DLFloat16,
// with merged exception flags and a sticky flag register.
module dlfloat_round
  import dlfloat_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [FLG_W-1:0] in_flags,
  input  logic [1:0]       rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [FLG_W-1:0] out_flags,
  output logic [FLG_W-1:0] sticky_flags,
  input  logic             flags_clr
);

  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W-1:0] in_frac;
  rnd_mode_e         in_mode;
  logic              in_incr;
  logic              in_inx;
  logic              in_special;
  logic [OUT_W-1:0]  in_spec_data;

  assign in_sign = in_data[IN_W-1];
  assign in_exp  = in_data[IN_W-2 -: EXP_W];
  assign in_frac = in_data[FRAC_W-1:0];
  assign in_mode = rnd_mode_e'(rnd_mode);

  dlfloat_rnd_decide u_decide (
    .sign    (in_sign),
    .lsb     (in_frac[EXT_W]),
    .g       (in_frac[EXT_W-1]),
    .s       (|in_frac[EXT_W-2:0]),
    .mode    (in_mode),
    .incr    (in_incr),
    .inexact (in_inx)
  );

  always_comb begin
    in_special   = 1'b0;
    in_spec_data = '0;
    if (in_exp == EXP_MAX) begin
      in_special   = 1'b1;
      in_spec_data = (in_frac == '0) ? {in_sign, MAG_INF} : CANON_NAN;
    end else if (in_exp == '0) begin
      in_special   = 1'b1;
      in_spec_data = {in_sign, {(OUT_W-1){1'b0}}};
    end
  end

  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  logic out_hs;

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_hs    = out_valid && out_ready;

  logic             s1_sign;
  logic [OUT_W-2:0] s1_mag;
  logic             s1_incr;
  logic             s1_inx;
  logic             s1_special;
  logic [OUT_W-1:0] s1_spec_data;
  logic [FLG_W-1:0] s1_flags;
  rnd_mode_e        s1_mode;

  // Mode is captured alongside the word so a mid-stall change cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_mag       <= '0;
      s1_incr      <= 1'b0;
      s1_inx       <= 1'b0;
      s1_special   <= 1'b0;
      s1_spec_data <= '0;
      s1_flags     <= '0;
      s1_mode      <= RNE;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_load) begin
        s1_sign      <= in_sign;
        s1_mag       <= {in_exp, in_frac[FRAC_W-1:EXT_W]};
        s1_incr      <= in_incr;
        s1_inx       <= in_inx;
        s1_special   <= in_special;
        s1_spec_data <= in_spec_data;
        s1_flags     <= in_flags;
        s1_mode      <= in_mode;
      end
    end
  end

  logic [OUT_W-2:0] rnd_mag;
  logic [OUT_W-1:0] nxt_data;
  logic [FLG_W-1:0] nxt_flags;

  // Mantissa carry ripples into the exponent through the shared adder.
  assign rnd_mag = s1_mag + (OUT_W-1)'(s1_incr);

  always_comb begin
    nxt_data  = {s1_sign, rnd_mag};
    nxt_flags = s1_flags;
    if (s1_special) begin
      nxt_data = s1_spec_data;
    end else begin
      nxt_flags[FLG_INX] = s1_flags[FLG_INX] | s1_inx;
      if (rnd_mag[OUT_W-2 -: EXP_W] == EXP_MAX) begin
        nxt_data           = ovf_result(s1_sign, s1_mode);
        nxt_flags[FLG_OVF] = 1'b1;
        nxt_flags[FLG_INX] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= nxt_data;
        out_flags <= nxt_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (flags_clr) begin
      sticky_flags <= out_hs ? out_flags : '0;
    end else if (out_hs) begin
      sticky_flags <= sticky_flags | out_flags;
    end
  end

endmodule

// File: tb/tb_dlfloat_round.sv
// Self-checking bench for dlfloat_round: directed rounding cases, backpressure,
// sticky flags, reset, and randomized traffic against an arithmetic model.
module tb_dlfloat_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic [4:0]  in_flags = '0;
  logic [1:0]  rnd_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [4:0]  out_flags;
  logic [4:0]  sticky_flags;
  logic        flags_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlfloat_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_flags     (in_flags),
    .rnd_mode     (rnd_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr)
  );

  // Reference: treat {exp,mantissa} as an integer magnitude, the low 4 bits
  // as a remainder in sixteenths of an ulp.
  function automatic logic [20:0] ref_round(input logic [19:0] d, input logic [4:0] fl,
                                            input logic [1:0] md);
    int e, f, mag, rem;
    logic sign, up, ovf;
    logic [4:0] of;
    logic [15:0] od;
    sign = d[19];
    e = int'(d[18:13]);
    f = int'(d[12:0]);
    if (e == 63) begin
      od = (f == 0) ? (sign ? 16'hfe00 : 16'h7e00) : 16'h7fff;
      return {fl, od};
    end
    if (e == 0) begin
      od = sign ? 16'h8000 : 16'h0000;
      return {fl, od};
    end
    mag = e * 512 + f / 16;
    rem = f % 16;
    case (md)
      2'd0:    up = (rem > 8) || (rem == 8 && (mag % 2) == 1);
      2'd1:    up = 1'b0;
      2'd2:    up = !sign && rem != 0;
      default: up = sign && rem != 0;
    endcase
    mag = mag + (up ? 1 : 0);
    ovf = (mag >= 63 * 512);
    of = fl;
    if (rem != 0) of[0] = 1'b1;
    if (ovf) begin
      of[0] = 1'b1;
      of[2] = 1'b1;
      if (md == 2'd0 || (md == 2'd2 && !sign) || (md == 2'd3 && sign)) mag = 63 * 512;
      else mag = 62 * 512 + 511;
    end
    od = {sign, mag[14:0]};
    return {of, od};
  endfunction

  function automatic logic [19:0] gen_in();
    logic [19:0] d;
    d = 20'($urandom);
    case ($urandom_range(0, 7))
      0: d[18:13] = 6'd62;
      1: begin
        d[18:13] = 6'd63;
        if ($urandom_range(0, 1) == 0) d[12:0] = '0;
      end
      2: d[18:13] = 6'd0;
      3: begin
        d[18:13] = 6'd62;
        d[12:4]  = 9'h1ff;
      end
      default: ;
    endcase
    return d;
  endfunction

  // Single-word transfer: returns observed output and cycles from handshake.
  task automatic xfer(input logic [19:0] d, input logic [4:0] fl, input logic [1:0] md,
                      input logic clr, output logic [15:0] od, output logic [4:0] of,
                      output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_flags = fl; rnd_mode = md; out_ready = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 20'($urandom);
    rnd_mode = 2'($urandom);
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    od = out_data;
    of = out_flags;
    flags_clr = clr;
    @(posedge clk);
    @(negedge clk);
    flags_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    checks++; if (out_flags !== 5'h0) begin errors++; $display("FAIL reset_out_flags got %b exp 00000", out_flags); end
    checks++; if (sticky_flags !== 5'h0) begin errors++; $display("FAIL reset_sticky got %b exp 00000", sticky_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [19:0] td [14] = '{20'h3e000, 20'h3e018, 20'h3e008, 20'h3d000, 20'h7dfff, 20'h7dfff,
                             20'hfdfff, 20'h7e000, 20'h7e100, 20'h80000, 20'hfdfff, 20'h7dfff,
                             20'h7dfff, 20'h3e008};
    logic [4:0]  tf [14] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                             5'b00000, 5'b01000, 5'b10000, 5'b00000, 5'b00000, 5'b00000,
                             5'b00000, 5'b00000};
    logic [1:0]  tm [14] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0,
                             2'd3, 2'd2, 2'd3, 2'd2};
    logic [15:0] eo [14] = '{16'h3e00, 16'h3e02, 16'h3e00, 16'h3d00, 16'h7e00, 16'h7dff,
                             16'hfdff, 16'h7e00, 16'h7fff, 16'h8000, 16'hfe00, 16'h7e00,
                             16'h7dff, 16'h3e01};
    logic [4:0]  ef [14] = '{5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00101, 5'b00001,
                             5'b00001, 5'b01000, 5'b10000, 5'b00000, 5'b00101, 5'b00101,
                             5'b00001, 5'b00001};
    logic [15:0] od;
    logic [4:0]  of;
    int lat;
    for (int i = 0; i < 14; i++) begin
      xfer(td[i], tf[i], tm[i], 1'b0, od, of, lat);
      checks++; if (od !== eo[i]) begin errors++; $display("FAIL dir_data[%0d] got %h exp %h", i, od, eo[i]); end
      checks++; if (of !== ef[i]) begin errors++; $display("FAIL dir_flags[%0d] got %b exp %b", i, of, ef[i]); end
      checks++; if (lat != 2) begin errors++; $display("FAIL dir_latency[%0d] got %0d exp 2", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] w [3] = '{20'h3e018, 20'h3d000, 20'h7dfff};
    logic [20:0] exp_q[$];
    logic [20:0] e;
    int acc, got, stall_bad;
    acc = 0; got = 0; stall_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = (acc < 3);
      in_data = w[acc < 3 ? acc : 2]; in_flags = '0; rnd_mode = 2'd0;
      #1;
      if (out_valid && exp_q.size() > 0 && out_data !== exp_q[0][15:0]) stall_bad++;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_round(w[acc], 5'b0, 2'd0));
        acc++;
      end
    end
    @(negedge clk);
    #1;
    checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h3e02) begin errors++; $display("FAIL bp_held got v=%b %h exp v=1 3e02", out_valid, out_data); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_bad); end
    for (int c = 0; c < 12 && !(got == 3 && acc == 3); c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (acc < 3);
      in_data = w[acc < 3 ? acc : 2];
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_round(w[acc], 5'b0, 2'd0));
        acc++;
      end
      if (out_valid) begin
        got++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h1fffff;
        checks++;
        if ({out_flags, out_data} !== e) begin
          errors++; $display("FAIL bp_order[%0d] got %b/%h exp %b/%h", got, out_flags, out_data, e[20:16], e[15:0]);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (got != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got out_valid %b exp 0", out_valid); end
  endtask

  task automatic test_sticky();
    logic [15:0] od;
    logic [4:0]  of;
    int lat;
    xfer(20'h3e000, 5'b00000, 2'd0, 1'b1, od, of, lat);
    checks++; if (sticky_flags !== 5'b00000) begin errors++; $display("FAIL sticky_clr0 got %b exp 00000", sticky_flags); end
    xfer(20'h3e008, 5'b00000, 2'd0, 1'b0, od, of, lat);
    xfer(20'h3e000, 5'b00100, 2'd0, 1'b0, od, of, lat);
    checks++; if (sticky_flags !== 5'b00101) begin errors++; $display("FAIL sticky_accum got %b exp 00101", sticky_flags); end
    xfer(20'h3e000, 5'b01000, 2'd0, 1'b1, od, of, lat);
    checks++; if (sticky_flags !== 5'b01000) begin errors++; $display("FAIL sticky_clr_hs got %b exp 01000", sticky_flags); end
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    checks++; if (sticky_flags !== 5'b00000) begin errors++; $display("FAIL sticky_clr got %b exp 00000", sticky_flags); end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [20:0] q[$];
    logic [4:0]  sticky_m;
    int sent, recvd;
    sent = 0; recvd = 0;
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    sticky_m = '0;
    fork
      begin
        int cyc;
        cyc = 0;
        while (sent < N && cyc < 4000) begin
          @(negedge clk);
          cyc++;
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = gen_in();
          in_flags = 5'($urandom);
          rnd_mode = 2'($urandom);
          #1;
          if (in_valid && in_ready) begin
            q.push_back(ref_round(in_data, in_flags, rnd_mode));
            sent++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int cyc;
        logic hs;
        logic [4:0] ef;
        cyc = 0;
        while (recvd < N && cyc < 6000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          flags_clr = ($urandom_range(0, 15) == 0);
          #1;
          hs = out_valid && out_ready;
          ef = '0;
          if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
              errors++; $display("FAIL rand_extra got %h with nothing expected", out_data);
            end else begin
              ef = q[0][20:16];
              if ({out_flags, out_data} !== q[0]) begin
                errors++; $display("FAIL rand_word got %b/%h exp %b/%h", out_flags, out_data, q[0][20:16], q[0][15:0]);
              end
              if (hs) begin
                void'(q.pop_front());
                recvd++;
              end
            end
          end
          if (flags_clr) sticky_m = hs ? ef : 5'b0;
          else if (hs) sticky_m = sticky_m | ef;
          @(posedge clk);
          #1;
          checks++;
          if (sticky_flags !== sticky_m) begin
            errors++; $display("FAIL rand_sticky got %b exp %b", sticky_flags, sticky_m);
          end
        end
        flags_clr = 1'b0;
      end
    join
    checks++; if (recvd != N) begin errors++; $display("FAIL rand_count got %0d exp %0d", recvd, N); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d exp 0", q.size()); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] od;
    logic [4:0]  of;
    int lat, stray;
    xfer(20'h3e018, 5'b00000, 2'd0, 1'b1, od, of, lat);
    checks++; if (sticky_flags !== 5'b00001) begin errors++; $display("FAIL mr_pre_sticky got %b exp 00001", sticky_flags); end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 20'h3e008; in_flags = 5'b00100; rnd_mode = 2'd0;
    @(negedge clk);
    in_data = 20'h3d000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_loaded got %b exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got %b exp 0", out_valid); end
    checks++; if (sticky_flags !== 5'b00000) begin errors++; $display("FAIL mr_sticky got %b exp 00000", sticky_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    xfer(20'h3e018, 5'b00000, 2'd0, 1'b0, od, of, lat);
    checks++; if (od !== 16'h3e02) begin errors++; $display("FAIL mr_data got %h exp 3e02", od); end
    checks++; if (of !== 5'b00001) begin errors++; $display("FAIL mr_flags got %b exp 00001", of); end
    checks++; if (lat != 2) begin errors++; $display("FAIL mr_latency got %0d exp 2", lat); end
    checks++; if (sticky_flags !== 5'b00001) begin errors++; $display("FAIL mr_post_sticky got %b exp 00001", sticky_flags); end
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mr_stale got %0d words exp 0", stray); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_sticky();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
